apb_master_arbiter: RTL and testbench
=====================================

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, the APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, the APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of ACCESS cycles before an abort (used only with APB_ARB_TIMEOUT_EN).
REQ-004 SHALL have these ports: clk_i input 1, the single clock. Reset is synchronous, active-high.
REQ-005 rst_i input 1, synchronous active-high reset.
REQ-006 req_i input [1:0], transfer request per requester; r0 is the core and r1 is debug.
REQ-007 addr_i input [1:0][APB_ADDR_WIDTH-1:0], transfer address per requester.
REQ-008 we_i input [1:0], write enable per requester.
REQ-009 wdata_i input [1:0][APB_DATA_WIDTH-1:0], write data per requester.
REQ-010 gnt_o output [1:0], one-hot grant pulse.
REQ-011 rvalid_o output [1:0], one-hot response pulse.
REQ-012 rdata_o output APB_DATA_WIDTH, read data shared by both requesters.
REQ-013 err_o output 1, response error, valid while rvalid_o is high.
REQ-014 paddr_o, pwdata_o, pwrite_o, psel_o and penable_o are the APB master outputs.
REQ-015 prdata_i, pready_i and pslverr_i are the APB master inputs.

Function
REQ-016 SHALL implement an FSM with the states IDLE, SETUP and ACCESS.
REQ-017 In IDLE with any req_i high: SHALL combinationally raise gnt_o[w] for the winner w in the same cycle, latch addr_i[w], we_i[w] and wdata_i[w], record w as the owner, and go to SETUP.
REQ-018 Arbitration SHALL be round-robin: if only one requester asks, it wins; if both ask, the requester not granted last wins; the last-granted pointer resets to r1, so r0 wins the first conflict.
REQ-019 In SETUP: psel_o=1, penable_o=0, paddr_o, pwdata_o and pwrite_o come from the latch; the FSM SHALL go to ACCESS unconditionally.
REQ-020 In ACCESS: psel_o=1 and penable_o=1; the FSM SHALL stay while pready_i=0.
REQ-021 In ACCESS with pready_i=1: SHALL register prdata_i into rdata_o and pslverr_i into err_o, pulse rvalid_o[owner] for exactly the next cycle, and go to IDLE.
REQ-022 Latency from req_i to rvalid_o with a zero-wait slave SHALL be 3 cycles: gnt at cycle 0, SETUP at 1, ACCESS at 2, rvalid at 3.
REQ-023 A new grant SHALL be possible in the same cycle that rvalid_o is high, giving a back-to-back period of 3 cycles.
REQ-024 gnt_o SHALL be 0 outside IDLE; requests arriving during a transfer SHALL be held off and are never dropped.
REQ-025 paddr_o, pwdata_o and pwrite_o SHALL stay stable from SETUP through the final ACCESS cycle.
REQ-026 rdata_o and err_o SHALL hold their values until the next response; rdata_o is undefined on writes, and a zero is acceptable.

Reset
REQ-027 On rst_i=1 at a clock edge, the block SHALL enter IDLE and drive psel_o, penable_o, pwrite_o, gnt_o, rvalid_o and err_o to 0; paddr_o, pwdata_o and rdata_o SHALL be 0; the RR pointer SHALL be r1.
REQ-028 A reset mid-transfer SHALL drop psel_o and penable_o at that edge, and no rvalid_o SHALL follow.
REQ-029 gnt_o SHALL be 0 while rst_i is high.

Configuration
REQ-030 The macro APB_ARB_TIMEOUT_EN, when defined, SHALL add a counter that clears on entry to ACCESS and increments in each ACCESS cycle without pready_i.
REQ-031 When the counter reaches TIMEOUT_CYCLES, the block SHALL abort: go to IDLE, drop psel_o and penable_o, pulse rvalid_o[owner] with err_o=1 and rdata_o=0.
REQ-032 If pready_i is high in the timeout cycle, normal completion SHALL win.
REQ-033 Without the macro there SHALL be no counter, and ACCESS waits indefinitely.

Structure
REQ-034 A shared package apb_arb_pkg SHALL hold the state enum type (IDLE, SETUP, ACCESS) and the requester index constants REQ_CORE=0 and REQ_DBG=1.
REQ-035 The round-robin picker SHALL be a sub-module, rr_arb_2, that takes req[1:0] and the last pointer and returns a one-hot winner.

Verification
REQ-036 Single read: r0 reads 0x1A10_0000, the slave returns 0xDEAD_BEEF with pready=1 at once -> gnt_o=01 at cycle 0, SETUP at 1, ACCESS at 2, rvalid_o=01 at cycle 3 with rdata_o=0xDEAD_BEEF and err_o=0.
REQ-037 Conflict: req_i=11 held continuously, all writes -> grants alternate 01, 10, 01, 10, each 3 cycles apart, and paddr_o matches the granted requester.
REQ-038 Wait states and error: r1 writes with 4 cycles of pready=0, then pready=1 with pslverr=1 -> penable_o is high for 5 cycles, paddr_o and pwdata_o stay stable, and rvalid_o=10 with err_o=1.
REQ-039 Reset mid-ACCESS: assert rst_i during ACCESS -> psel_o=0 at the next edge, no rvalid_o, and after release r0 wins a conflicting request.
REQ-040 Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): pready held 0 -> after 8 ACCESS cycles psel_o=0 and rvalid_o pulses for the owner with err_o=1 and rdata_o=0; without the macro, psel_o stays high for more than 100 cycles.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared state type, requester indices and a small index helper for the APB master arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } arb_state_e;

   localparam int unsigned REQ_CORE = 0;
   localparam int unsigned REQ_DBG  = 1;

   function automatic logic [1:0] idx_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB master-side bus bundle; the arbiter drives it through the master modport.
interface apb_master_arbiter_if #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32
);

   logic [APB_ADDR_WIDTH-1:0] paddr_o;
   logic [APB_DATA_WIDTH-1:0] pwdata_o;
   logic                      pwrite_o;
   logic                      psel_o;
   logic                      penable_o;
   logic [APB_DATA_WIDTH-1:0] prdata_i;
   logic                      pready_i;
   logic                      pslverr_i;

   modport master (
      output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
      input  prdata_i, pready_i, pslverr_i
   );

   modport slave (
      input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
      output prdata_i, pready_i, pslverr_i
   );

endinterface

// File: rtl/rr_arb_2.sv
// Two-way round-robin picker, purely combinational: a lone requester wins,
// on conflict the one not granted last wins.
module rr_arb_2
   import apb_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req[REQ_CORE] && req[REQ_DBG]) begin
         gnt = idx_onehot(~last);
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: grant in IDLE, SETUP, ACCESS, response one cycle after pready (3 cycles min).
// Requests are held off (not dropped) while busy; APB_ARB_TIMEOUT_EN adds an ACCESS timeout abort.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [1:0]                          req_i,
   input  logic [1:0][APB_ADDR_WIDTH-1:0]      addr_i,
   input  logic [1:0]                          we_i,
   input  logic [1:0][APB_DATA_WIDTH-1:0]      wdata_i,
   output logic [1:0]                          gnt_o,
   output logic [1:0]                          rvalid_o,
   output logic [APB_DATA_WIDTH-1:0]           rdata_o,
   output logic                                err_o,
   apb_master_arbiter_if.master                apb
);

   arb_state_e                state_q,   state_d;
   logic                      owner_q,   owner_d;
   logic                      last_q,    last_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q,   paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
   logic                      pwrite_q,  pwrite_d;
   logic                      psel_q,    psel_d;
   logic                      penable_q, penable_d;
   logic [APB_DATA_WIDTH-1:0] rdata_q,   rdata_d;
   logic                      err_q,     err_d;
   logic [1:0]                rvalid_q,  rvalid_d;

   logic [1:0] win;
   logic       win_idx;

   rr_arb_2 u_rr_arb (
      .req  (req_i),
      .last (last_q),
      .gnt  (win)
   );

   assign win_idx = win[REQ_DBG];
   assign gnt_o   = (state_q == IDLE && !rst_i) ? win : 2'b00;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_hit;

   // This is the last allowed wait cycle: the counter would reach the limit here.
   assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic tmo_unused;
   assign tmo_unused = (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      rvalid_d  = 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|req_i) begin
               owner_d   = win_idx;
               last_d    = win_idx;
               paddr_d   = addr_i[win_idx];
               pwdata_d  = wdata_i[win_idx];
               pwrite_d  = we_i[win_idx];
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         ACCESS: begin
            if (apb.pready_i) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               rdata_d   = apb.prdata_i;
               err_d     = apb.pslverr_i;
               rvalid_d  = idx_onehot(owner_q);
               state_d   = IDLE;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               rdata_d   = '0;
               err_d     = 1'b1;
               rvalid_d  = idx_onehot(owner_q);
               state_d   = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         rvalid_q  <= 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         rvalid_q  <= rvalid_d;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
`endif
      end
   end

   assign apb.paddr_o   = paddr_q;
   assign apb.pwdata_o  = pwdata_q;
   assign apb.pwrite_o  = pwrite_q;
   assign apb.psel_o    = psel_q;
   assign apb.penable_o = penable_q;
   assign rdata_o       = rdata_q;
   assign err_o         = err_q;
   assign rvalid_o      = rvalid_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter; timeout case follows APB_ARB_TIMEOUT_EN.
module tb_apb_master_arbiter;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [1:0]        req_i;
   logic [1:0][31:0]  addr_i;
   logic [1:0]        we_i;
   logic [1:0][31:0]  wdata_i;
   logic [1:0]        gnt_o;
   logic [1:0]        rvalid_o;
   logic [31:0]       rdata_o;
   logic              err_o;

   int errors = 0;
   int checks = 0;

   apb_master_arbiter_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apb ();

   apb_master_arbiter #(
      .APB_ADDR_WIDTH (32),
      .APB_DATA_WIDTH (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_i),
      .addr_i   (addr_i),
      .we_i     (we_i),
      .wdata_i  (wdata_i),
      .gnt_o    (gnt_o),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o),
      .apb      (apb)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [1:0]  exp_gnt;
      logic [31:0] exp_addr;
      int          pen_cycles;

      rst_i          = 1'b1;
      req_i          = 2'b11;
      addr_i         = '0;
      we_i           = 2'b00;
      wdata_i        = '0;
      apb.prdata_i   = '0;
      apb.pready_i   = 1'b0;
      apb.pslverr_i  = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_gnt",     gnt_o,         2'b00);
      check("rst_psel",    apb.psel_o,    1'b0);
      check("rst_penable", apb.penable_o, 1'b0);
      check("rst_pwrite",  apb.pwrite_o,  1'b0);
      check("rst_rvalid",  rvalid_o,      2'b00);
      check("rst_err",     err_o,         1'b0);
      check("rst_paddr",   apb.paddr_o,   32'h0);
      check("rst_pwdata",  apb.pwdata_o,  32'h0);
      check("rst_rdata",   rdata_o,       32'h0);
      req_i = 2'b00;
      rst_i = 1'b0;
      tick();

      // Single read by the core, zero-wait slave
      req_i     = 2'b01;
      addr_i[0] = 32'h1A10_0000;
      we_i      = 2'b00;
      #1;
      check("rd_gnt_c0", gnt_o, 2'b01);
      tick();
      req_i = 2'b00;
      check("rd_psel_c1",    apb.psel_o,    1'b1);
      check("rd_penable_c1", apb.penable_o, 1'b0);
      check("rd_paddr_c1",   apb.paddr_o,   32'h1A10_0000);
      check("rd_pwrite_c1",  apb.pwrite_o,  1'b0);
      check("rd_gnt_busy",   gnt_o,         2'b00);
      apb.pready_i = 1'b1;
      apb.prdata_i = 32'hDEAD_BEEF;
      tick();
      check("rd_penable_c2", apb.penable_o, 1'b1);
      check("rd_rvalid_c2",  rvalid_o,      2'b00);
      tick();
      check("rd_rvalid_c3", rvalid_o,   2'b01);
      check("rd_rdata_c3",  rdata_o,    32'hDEAD_BEEF);
      check("rd_err_c3",    err_o,      1'b0);
      check("rd_psel_c3",   apb.psel_o, 1'b0);
      tick();
      check("rd_rvalid_c4", rvalid_o, 2'b00);
      check("rd_rdata_hold", rdata_o, 32'hDEAD_BEEF);

      // Conflict: core was granted last, so debug wins first, then alternation
      req_i     = 2'b11;
      we_i      = 2'b11;
      addr_i[0] = 32'h0000_00A0;
      addr_i[1] = 32'h0000_00B0;
      wdata_i[0] = 32'h1111_0000;
      wdata_i[1] = 32'h2222_0000;
      exp_gnt   = 2'b10;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cf_gnt", gnt_o, exp_gnt);
         exp_addr = exp_gnt[1] ? 32'h0000_00B0 : 32'h0000_00A0;
         tick();
         check("cf_paddr",  apb.paddr_o,  exp_addr);
         check("cf_pwrite", apb.pwrite_o, 1'b1);
         check("cf_gnt_hold", gnt_o, 2'b00);
         tick();
         check("cf_penable", apb.penable_o, 1'b1);
         tick();
         check("cf_rvalid", rvalid_o, exp_gnt);
         exp_gnt = ~exp_gnt;
      end
      req_i = 2'b00;
      tick();

      // Debug write with four wait states then a slave error
      req_i        = 2'b10;
      addr_i[1]    = 32'h4000_0010;
      wdata_i[1]   = 32'hCAFE_F00D;
      we_i         = 2'b10;
      apb.pready_i = 1'b0;
      #1;
      check("ws_gnt", gnt_o, 2'b10);
      tick();
      req_i = 2'b00;
      check("ws_pwrite", apb.pwrite_o, 1'b1);
      tick();
      pen_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         if (apb.penable_o) pen_cycles++;
         check("ws_paddr_stable",  apb.paddr_o,  32'h4000_0010);
         check("ws_pwdata_stable", apb.pwdata_o, 32'hCAFE_F00D);
         check("ws_rvalid_wait",   rvalid_o,     2'b00);
         tick();
      end
      apb.pready_i  = 1'b1;
      apb.pslverr_i = 1'b1;
      if (apb.penable_o) pen_cycles++;
      check("ws_paddr_last", apb.paddr_o, 32'h4000_0010);
      tick();
      apb.pready_i  = 1'b0;
      apb.pslverr_i = 1'b0;
      check("ws_penable_cycles", pen_cycles, 5);
      check("ws_rvalid", rvalid_o,      2'b10);
      check("ws_err",    err_o,         1'b1);
      check("ws_penable_off", apb.penable_o, 1'b0);
      tick();

      // Reset during ACCESS: core granted, debug would win without the pointer reset
      req_i     = 2'b01;
      addr_i[0] = 32'h0000_1234;
      we_i      = 2'b00;
      #1;
      check("rm_gnt", gnt_o, 2'b01);
      tick();
      req_i = 2'b00;
      tick();
      check("rm_access", apb.penable_o, 1'b1);
      rst_i = 1'b1;
      req_i = 2'b11;
      #1;
      check("rm_gnt_in_rst", gnt_o, 2'b00);
      tick();
      check("rm_psel",    apb.psel_o,    1'b0);
      check("rm_penable", apb.penable_o, 1'b0);
      check("rm_rvalid",  rvalid_o,      2'b00);
      rst_i = 1'b0;
      #1;
      check("rm_conflict_gnt", gnt_o, 2'b01);
      tick();
      req_i = 2'b00;
      check("rm_rvalid_after", rvalid_o, 2'b00);
      check("rm_paddr", apb.paddr_o, 32'h0000_1234);
      apb.pready_i = 1'b1;
      apb.prdata_i = 32'h5A5A_0001;
      tick();
      tick();
      check("rm_rvalid_done", rvalid_o, 2'b01);
      check("rm_rdata",       rdata_o,  32'h5A5A_0001);
      apb.pready_i = 1'b0;
      tick();

      // Slave never ready
      req_i        = 2'b10;
      we_i         = 2'b00;
      apb.prdata_i = 32'hFFFF_FFFF;
      #1;
      check("to_gnt", gnt_o, 2'b10);
      tick();
      req_i = 2'b00;
      tick();
`ifdef APB_ARB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         check("to_psel_wait", apb.psel_o, 1'b1);
         tick();
      end
      check("to_psel_abort", apb.psel_o,    1'b0);
      check("to_penable",    apb.penable_o, 1'b0);
      check("to_rvalid",     rvalid_o,      2'b10);
      check("to_err",        err_o,         1'b1);
      check("to_rdata",      rdata_o,       32'h0);
      tick();
      check("to_rvalid_pulse", rvalid_o, 2'b00);
`else
      for (int i = 0; i < 110; i++) begin
         check("nto_psel", apb.psel_o, 1'b1);
         tick();
      end
      check("nto_rvalid", rvalid_o, 2'b00);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("nto_psel_rst", apb.psel_o, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
